vcve2_vrf_responder: RTL and testbench
======================================

VCVE2_VRF_RESPONDER -- requirements
Module: vcve2_vrf_responder

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register length in bits; legal values are multiples of 32 and at least 64.
REQ-002 SHALL have parameter NumVRegs, default 32, number of vector registers; the address width is 5 bits.
REQ-003 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have req_i, input, 1, access request from the vector sequencer.
REQ-006 SHALL have req_we_i, input, 1, request type: 1 = write, 0 = read.
REQ-007 SHALL have req_addr_i, input, 5, vector register index.
REQ-008 SHALL have gnt_o, output, 1, request accepted.
REQ-009 SHALL have wdata_i, input, 32, write beat data.
REQ-010 SHALL have wvalid_i, input, 1, write beat valid.
REQ-011 SHALL have wready_o, output, 1, write beat ready.
REQ-012 SHALL have rdata_o, output, 32, read beat data.
REQ-013 SHALL have rvalid_o, output, 1, read beat valid.
REQ-014 SHALL have rready_i, input, 1, read beat ready.
REQ-015 SHALL have busy_o, output, 1, transfer in progress.

Function
REQ-016 SHALL hold NumVRegs registers of VLEN bits, each moved as N = VLEN/32 beats of 32 bits; beat k carries bits [32k+31:32k].
REQ-017 SHALL implement the FSM states IDLE, READ and WRITE.
REQ-018 SHALL drive gnt_o = 1 only in IDLE; a request is accepted when req_i && gnt_o.
REQ-019 SHALL, on acceptance, latch req_addr_i and req_we_i, clear the beat counter, and enter WRITE if req_we_i = 1 or READ if req_we_i = 0, all in the next cycle.
REQ-020 SHALL ignore req_i, req_we_i and req_addr_i outside IDLE; addr/type changes after acceptance have no effect.
REQ-021 READ: rvalid_o = 1 in every READ cycle; rdata_o = beat[counter] of the latched register; the first beat is valid exactly 1 cycle after the accept.
REQ-022 READ: a beat transfers on rvalid_o && rready_i; the counter increments on each transfer.
REQ-023 READ: while rready_i = 0, rdata_o and the counter SHALL hold stable.
REQ-024 READ: the transfer of beat N-1 returns the FSM to IDLE in the next cycle; gnt_o is 1 in that cycle, giving a minimum 1-cycle gap between accesses.
REQ-025 WRITE: wready_o = 1 in every WRITE cycle; on wvalid_i && wready_o, wdata_i is written to beat[counter] of the latched register, the counter increments, and the transfer of beat N-1 returns the FSM to IDLE.
REQ-026 WRITE: while wvalid_i = 0, the register file and the counter SHALL hold.
REQ-027 Written data SHALL be visible to any read accepted after the final write beat; a partial write leaves unwritten beats unchanged.
REQ-028 rdata_o SHALL be 0 when rvalid_o = 0; wready_o = 0 outside WRITE; rvalid_o = 0 outside READ.
REQ-029 busy_o SHALL be 1 in READ and WRITE, 0 in IDLE.
REQ-030 The counter width SHALL be $clog2(N); no wrap past N-1 is reachable.
REQ-031 Any register index (0 to NumVRegs-1) SHALL be readable and writable; v0 has no special treatment.

Reset
REQ-032 While rst_ni = 0: FSM = IDLE, counter = 0, all storage = 0, gnt_o = 1, rvalid_o = 0, wready_o = 0, rdata_o = 0, busy_o = 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately; no further beats occur and the partially written register reads 0 after reset.

Verification
REQ-034 After reset, read v5 with rready_i = 1 -> gnt_o = 1 on the request cycle; rvalid_o = 1 for 4 consecutive cycles with data 0; then IDLE.
REQ-035 Write v3 with beats 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, then read v3 -> beats return in the same order; busy_o = 0 one cycle after the last beat.
REQ-036 Read v3 with rready_i toggling 1,0,0,1,1,0,1 -> each beat is held stable while rready_i = 0; exactly 4 transfers occur.
REQ-037 During WRITE to v7, assert req_i for v9 and pull wvalid_i low for 3 cycles -> gnt_o stays 0 and the counter holds; v9 is untouched and v7 completes correctly.
REQ-038 Assert rst_ni low after 2 write beats to v1 -> outputs are at reset values at once; a subsequent read of v1 returns all 0.

Source files
------------

// File: rtl/vcve2_vrf_responder_if.sv
// Beat-level bus between the vector sequencer (master) and the VRF responder (slave).
interface vcve2_vrf_responder_if;
  logic        req_i;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic        gnt_o;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        rready_i;
  logic        busy_o;

  modport slave (
    input  req_i, req_we_i, req_addr_i, wdata_i, wvalid_i, rready_i,
    output gnt_o, wready_o, rdata_o, rvalid_o, busy_o
  );

  modport master (
    output req_i, req_we_i, req_addr_i, wdata_i, wvalid_i, rready_i,
    input  gnt_o, wready_o, rdata_o, rvalid_o, busy_o
  );
endinterface

// File: rtl/vcve2_vrf_responder.sv
// Vector register file responder: stores NumVRegs registers of VLEN bits and moves each
// one as VLEN/32 beats of 32 bits over a read or write beat channel.
module vcve2_vrf_responder #(
  parameter int unsigned VLEN     = 128,
  parameter int unsigned NumVRegs = 32
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  vcve2_vrf_responder_if.slave   bus
);

  localparam int unsigned NumBeats = VLEN / 32;
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        addr_q, addr_d;
  logic              mem_we;
  logic [VLEN-1:0]   mem_q [NumVRegs];

  // Next-state and handshake outputs; the latched access type lives in the state itself.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    mem_we       = 1'b0;
    bus.gnt_o    = 1'b0;
    bus.rvalid_o = 1'b0;
    bus.wready_o = 1'b0;
    bus.rdata_o  = '0;
    bus.busy_o   = 1'b1;
    unique case (state_q)
      StIdle: begin
        bus.gnt_o  = 1'b1;
        bus.busy_o = 1'b0;
        if (bus.req_i) begin
          addr_d  = bus.req_addr_i;
          cnt_d   = '0;
          state_d = bus.req_we_i ? StWrite : StRead;
        end
      end
      StRead: begin
        bus.rvalid_o = 1'b1;
        bus.rdata_o  = mem_q[addr_q][32*cnt_q +: 32];
        if (bus.rready_i) begin
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        bus.wready_o = 1'b1;
        if (bus.wvalid_i) begin
          mem_we = 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Register file; reset clears all storage so an aborted write leaves zeros behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumVRegs); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q][32*cnt_q +: 32] <= bus.wdata_i;
    end
  end

endmodule

// File: tb/tb_vcve2_vrf_responder.sv
// Directed bench for vcve2_vrf_responder with a transaction-level reference model.
module tb_vcve2_vrf_responder;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vcve2_vrf_responder_if bus ();

  vcve2_vrf_responder #(
    .VLEN     (128),
    .NumVRegs (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one outstanding transaction, plus the word-level contents.
  logic [31:0] mem_m [32][N];
  bit          txn_active = 1'b0;
  bit          txn_we     = 1'b0;
  int          txn_addr   = 0;
  int          txn_beat   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_active = 1'b0;
      txn_beat   = 0;
      for (int r = 0; r < 32; r++) for (int b = 0; b < N; b++) mem_m[r][b] = 32'h0;
    end else if (!txn_active) begin
      if (bus.req_i) begin
        txn_active = 1'b1;
        txn_we     = bus.req_we_i;
        txn_addr   = int'(bus.req_addr_i);
        txn_beat   = 0;
      end
    end else if (txn_we) begin
      if (bus.wvalid_i) begin
        mem_m[txn_addr][txn_beat] = bus.wdata_i;
        txn_beat++;
        if (txn_beat == N) txn_active = 1'b0;
      end
    end else if (bus.rready_i) begin
      txn_beat++;
      if (txn_beat == N) txn_active = 1'b0;
    end
  end

  // Compare every cycle on the falling edge, including cycles held in reset.
  always @(negedge clk) begin
    logic        rv;
    logic [31:0] rd;
    rv = txn_active && !txn_we;
    rd = rv ? mem_m[txn_addr][txn_beat] : 32'h0;
    check("gnt_o",    {31'b0, bus.gnt_o},    {31'b0, !txn_active});
    check("busy_o",   {31'b0, bus.busy_o},   {31'b0, txn_active});
    check("rvalid_o", {31'b0, bus.rvalid_o}, {31'b0, rv});
    check("wready_o", {31'b0, bus.wready_o}, {31'b0, txn_active && txn_we});
    check("rdata_o",  bus.rdata_o, rd);
  end

  logic [31:0] cap [$];
  logic [31:0] wd  [N];
  bit          pat [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a read; rready follows pat (then stays 1); captured beats land in cap.
  task automatic do_read(input int addr);
    int cyc;
    cap.delete();
    bus.req_i      = 1'b1;
    bus.req_we_i   = 1'b0;
    bus.req_addr_i = 5'(addr);
    check("gnt_on_req", {31'b0, bus.gnt_o}, 32'h1);
    step();
    bus.req_i = 1'b0;
    cyc = 0;
    while (cap.size() < N && cyc < 20) begin
      bus.rready_i = (cyc < pat.size()) ? pat[cyc] : 1'b1;
      #1;
      if (bus.rvalid_o && bus.rready_i) cap.push_back(bus.rdata_o);
      step();
      cyc++;
    end
    bus.rready_i = 1'b0;
    if (cap.size() < N) check("read_timeout", 32'(cap.size()), 32'(N));
    pat.delete();
  endtask

  // Issue a write of wd; wvalid follows pat (then 1); stops after stop_after beats.
  task automatic do_write(input int addr, input int stop_after);
    int cyc;
    int idx;
    bus.req_i      = 1'b1;
    bus.req_we_i   = 1'b1;
    bus.req_addr_i = 5'(addr);
    step();
    bus.req_i = 1'b0;
    cyc = 0;
    idx = 0;
    while (idx < stop_after && cyc < 20) begin
      bus.wvalid_i = (cyc < pat.size()) ? pat[cyc] : 1'b1;
      bus.wdata_i  = wd[idx];
      #1;
      if (bus.wvalid_i && bus.wready_o) idx++;
      step();
      cyc++;
    end
    bus.wvalid_i = 1'b0;
    if (idx < stop_after) check("write_timeout", 32'(idx), 32'(stop_after));
    pat.delete();
  endtask

  initial begin
    int xfers;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.wdata_i = '0; bus.wvalid_i = 1'b0; bus.rready_i = 1'b0;
    repeat (3) step();
    check("rst_gnt",  {31'b0, bus.gnt_o},  32'h1);
    check("rst_busy", {31'b0, bus.busy_o}, 32'h0);
    rst_n = 1'b1;
    step();

    // Read of untouched v5 returns four zero beats, then idle.
    do_read(5);
    check("v5_beats", 32'(cap.size()), 32'd4);
    for (int i = 0; i < N; i++) check("v5_data", cap[i], 32'h0);
    check("v5_idle", {31'b0, bus.busy_o}, 32'h0);

    // Write v3 then read it back in order.
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    do_write(3, N);
    check("v3_wr_busy", {31'b0, bus.busy_o}, 32'h0);
    do_read(3);
    check("v3_b0", cap[0], 32'h11111111);
    check("v3_b1", cap[1], 32'h22222222);
    check("v3_b2", cap[2], 32'h33333333);
    check("v3_b3", cap[3], 32'h44444444);
    check("v3_rd_busy", {31'b0, bus.busy_o}, 32'h0);

    // Back-pressured read: 1,0,0,1,1,0,1 gives exactly four transfers in seven cycles.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    do_read(3);
    xfers = cap.size();
    check("bp_xfers", 32'(xfers), 32'd4);
    check("bp_b3", cap[3], 32'h44444444);
    check("bp_busy", {31'b0, bus.busy_o}, 32'h0);

    // Write v7 while a competing request for v9 is held and wvalid stalls for 3 cycles.
    wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; wd[2] = 32'hC2C2C2C2; wd[3] = 32'hD3D3D3D3;
    bus.req_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 5'd7;
    step();
    bus.req_addr_i = 5'd9;
    bus.wvalid_i = 1'b1; bus.wdata_i = wd[0];
    step();
    bus.wvalid_i = 1'b0; bus.wdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("v7_gnt_stall", {31'b0, bus.gnt_o}, 32'h0);
      step();
    end
    for (int i = 1; i < N; i++) begin
      bus.wvalid_i = 1'b1; bus.wdata_i = wd[i];
      step();
    end
    bus.wvalid_i = 1'b0;
    bus.req_i    = 1'b0;
    do_read(9);
    for (int i = 0; i < N; i++) check("v9_untouched", cap[i], 32'h0);
    do_read(7);
    check("v7_b0", cap[0], 32'hA0A0A0A0);
    check("v7_b1", cap[1], 32'hB1B1B1B1);
    check("v7_b2", cap[2], 32'hC2C2C2C2);
    check("v7_b3", cap[3], 32'hD3D3D3D3);

    // Fill v1, begin a rewrite, abort it with reset after two beats.
    wd[0] = 32'h01010101; wd[1] = 32'h02020202; wd[2] = 32'h03030303; wd[3] = 32'h04040404;
    do_write(1, N);
    wd[0] = 32'hFFFF0000; wd[1] = 32'h0000FFFF;
    do_write(1, 2);
    check("abort_busy_pre", {31'b0, bus.busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_gnt",    {31'b0, bus.gnt_o},    32'h1);
    check("abort_busy",   {31'b0, bus.busy_o},   32'h0);
    check("abort_wready", {31'b0, bus.wready_o}, 32'h0);
    check("abort_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    check("abort_rdata",  bus.rdata_o,           32'h0);
    step();
    rst_n = 1'b1;
    step();
    do_read(1);
    for (int i = 0; i < N; i++) check("v1_after_rst", cap[i], 32'h0);
    do_read(3);
    check("v3_after_rst", cap[0], 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
